pick: RTL and testbench

PICK -- requirements
Module: pick

---
 rtl/pick_pkg.sv | 23 ++
 rtl/pick_hdr_det.sv | 45 ++++
 rtl/pick.sv | 108 ++++++++++
 tb/tb_pick.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pick_pkg.sv
// Shared types and default constants for the pick burst extractor.
// State encoding is common to the top and the header detector.
package pick_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HUNT  = 3'd1,
    SYNC1 = 3'd2,
    SYNC2 = 3'd3,
    PASS  = 3'd4
  } pick_state_e;

  localparam int          PICK_DATA_W    = 16;
  localparam logic [15:0] PICK_SYNC_WORD = 16'hFFFF;
  localparam logic [15:0] PICK_MARK_WORD = 16'hAAAA;
  localparam int          PICK_BURST_LEN = 16;

  // One extra bit so the counter can represent BURST_LEN itself without wrapping.
  function automatic int pickCntWidth(input int burstLen);
    return $clog2(burstLen) + 1;
  endfunction

endpackage

// File: rtl/pick_hdr_det.sv
// Header detector: next-state logic for HUNT/SYNC1/SYNC2, pulsing hdrFound
// on the marker word that completes a valid sync-sync-marker header.
module pick_hdr_det
  import pick_pkg::*;
#(
  parameter int                 DATA_W    = PICK_DATA_W,
  parameter logic [DATA_W-1:0]  SYNC_WORD = DATA_W'(PICK_SYNC_WORD),
  parameter logic [DATA_W-1:0]  MARK_WORD = DATA_W'(PICK_MARK_WORD)
) (
  input  pick_state_e        state_i,
  input  logic               go_i,
  input  logic [DATA_W-1:0]  din_i,
  output pick_state_e        next_o,
  output logic               hdrFound_o
);

  // Dropping GO anywhere in the header search abandons it before the word is considered.
  always_comb begin
    next_o     = state_i;
    hdrFound_o = 1'b0;
    case (state_i)
      HUNT: begin
        if (!go_i)                   next_o = IDLE;
        else if (din_i == SYNC_WORD) next_o = SYNC1;
      end
      SYNC1: begin
        if (!go_i)                   next_o = IDLE;
        else if (din_i == SYNC_WORD) next_o = SYNC2;
        else                         next_o = HUNT;
      end
      SYNC2: begin
        if (!go_i) begin
          next_o = IDLE;
        end else if (din_i == MARK_WORD) begin
          next_o     = PASS;
          hdrFound_o = 1'b1;
        end else if (din_i != SYNC_WORD) begin
          next_o = HUNT;
        end
      end
      default: next_o = state_i;
    endcase
  end

endmodule

// File: rtl/pick.sv
// pick: extracts BURST_LEN-word payloads following a SYNC,SYNC,MARK header.
// Define PICK_ASSERT_EN to compile in the SVA protocol checks.
module pick
  import pick_pkg::*;
#(
  parameter int                 DATA_W    = PICK_DATA_W,
  parameter logic [DATA_W-1:0]  SYNC_WORD = DATA_W'(PICK_SYNC_WORD),
  parameter logic [DATA_W-1:0]  MARK_WORD = DATA_W'(PICK_MARK_WORD),
  parameter int                 BURST_LEN = PICK_BURST_LEN
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               GO,
  input  logic [DATA_W-1:0]  DIN,
  output logic               PUSH,
  output logic [DATA_W-1:0]  PIXEL_DATA
);

  localparam int CNT_W = pickCntWidth(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  pick_state_e        state_q, state_d;
  pick_state_e        hdrNext;
  logic               hdrFound;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_q, push_d;
  logic [DATA_W-1:0]  pixel_q, pixel_d;

  pick_hdr_det #(
    .DATA_W    (DATA_W),
    .SYNC_WORD (SYNC_WORD),
    .MARK_WORD (MARK_WORD)
  ) u_hdr_det (
    .state_i    (state_q),
    .go_i       (GO),
    .din_i      (DIN),
    .next_o     (hdrNext),
    .hdrFound_o (hdrFound)
  );

  // PASS captures every word unconditionally, so header-like payload words are just data
  // and GO is only consulted once the final word has been taken.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    push_d  = 1'b0;
    pixel_d = pixel_q;
    case (state_q)
      IDLE: begin
        if (GO) state_d = HUNT;
      end
      PASS: begin
        push_d  = 1'b1;
        pixel_d = DIN;
        if (count_q == LAST_CNT) begin
          count_d = '0;
          state_d = GO ? HUNT : IDLE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = hdrNext;
        if (hdrFound) count_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      count_q <= '0;
      push_q  <= 1'b0;
      pixel_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      push_q  <= push_d;
      pixel_q <= pixel_d;
    end
  end

  assign PUSH       = push_q;
  assign PIXEL_DATA = pixel_q;

`ifdef PICK_ASSERT_EN
  int runLen_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    runLen_q <= 0;
    else if (PUSH) runLen_q <= runLen_q + 1;
    else           runLen_q <= 0;
  end

  a_push_run_bounded: assert property (@(posedge CLK) disable iff (!RST_N)
    runLen_q <= BURST_LEN);

  a_push_after_pass: assert property (@(posedge CLK) disable iff (!RST_N)
    PUSH |-> $past(state_q == PASS));

  a_state_legal: assert property (@(posedge CLK)
    state_q inside {IDLE, HUNT, SYNC1, SYNC2, PASS});

  a_reset_values: assert property (@(posedge CLK)
    !RST_N |-> (state_q == IDLE && count_q == '0 && !PUSH && PIXEL_DATA == '0));
`endif

endmodule

// File: tb/tb_pick.sv
// Directed self-checking bench for pick: header detection, burst timing,
// GO handling, payload-as-data and mid-burst reset.
module tb_pick;

  logic        CLK;
  logic        RST_N;
  logic        GO;
  logic [15:0] DIN;
  logic        PUSH;
  logic [15:0] PIXEL_DATA;

  int testsRun  = 0;
  int failCount = 0;

  logic [15:0] stimW[$];
  logic        stimGo[$];
  logic        obsPush[$];
  logic [15:0] obsData[$];

  pick dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .GO         (GO),
    .DIN        (DIN),
    .PUSH       (PUSH),
    .PIXEL_DATA (PIXEL_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic addWord(input logic [15:0] w, input logic g);
    stimW.push_back(w);
    stimGo.push_back(g);
  endtask

  task automatic clearStim();
    stimW.delete();
    stimGo.delete();
  endtask

  // One word per cycle; outputs recorded 1ns after the edge that sampled that word.
  task automatic applyStimulus();
    obsPush.delete();
    obsData.delete();
    for (int i = 0; i < stimW.size(); i++) begin
      DIN = stimW[i];
      GO  = stimGo[i];
      @(posedge CLK);
      #1;
      obsPush.push_back(PUSH);
      obsData.push_back(PIXEL_DATA);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b1; GO = 1'b0; DIN = '0;
    #2;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    testsRun++;
    if (PUSH !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_push got %b expected 0", PUSH);
    end
    testsRun++;
    if (PIXEL_DATA !== 16'h0000) begin
      failCount++; $display("[TB] FAIL reset_pixel got %h expected 0000", PIXEL_DATA);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_single_burst();
    logic expPush;
    clearStim();
    addWord(16'h0000, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hAAAA, 1'b1);
    for (int k = 0; k < 16; k++) addWord(16'hAAAB + 16'(k), 1'b1);
    repeat (3) addWord(16'h0000, 1'b1);
    applyStimulus();
    for (int i = 0; i < obsPush.size(); i++) begin
      expPush = (i >= 4 && i <= 19);
      testsRun++;
      if (obsPush[i] !== expPush) begin
        failCount++; $display("[TB] FAIL single_push[%0d] got %b expected %b", i, obsPush[i], expPush);
      end
      if (expPush) begin
        testsRun++;
        if (obsData[i] !== 16'hAAAB + 16'(i - 4)) begin
          failCount++; $display("[TB] FAIL single_data[%0d] got %h expected %h", i, obsData[i], 16'hAAAB + 16'(i - 4));
        end
      end
    end
    testsRun++;
    if (obsData[22] !== 16'hAABA) begin
      failCount++; $display("[TB] FAIL single_hold got %h expected aaba", obsData[22]);
    end
  endtask

  task automatic test_back_to_back();
    int pushes;
    int phase;
    logic expPush;
    clearStim();
    for (int b = 0; b < 3; b++) begin
      addWord(16'h0000, 1'b1);
      addWord(16'hFFFF, 1'b1);
      addWord(16'hFFFF, 1'b1);
      addWord(16'hAAAA, 1'b1);
      for (int k = 0; k < 16; k++) addWord(16'hAAAB + 16'(k), 1'b1);
      repeat (4) addWord(16'h0000, 1'b1);
    end
    applyStimulus();
    pushes = 0;
    for (int i = 0; i < obsPush.size(); i++) begin
      phase   = i % 24;
      expPush = (phase >= 4 && phase <= 19);
      if (obsPush[i] === 1'b1) pushes++;
      testsRun++;
      if (obsPush[i] !== expPush) begin
        failCount++; $display("[TB] FAIL b2b_push[%0d] got %b expected %b", i, obsPush[i], expPush);
      end
      if (expPush) begin
        testsRun++;
        if (obsData[i] !== 16'hAAAB + 16'(phase - 4)) begin
          failCount++; $display("[TB] FAIL b2b_data[%0d] got %h expected %h", i, obsData[i], 16'hAAAB + 16'(phase - 4));
        end
      end
    end
    testsRun++;
    if (pushes != 48) begin
      failCount++; $display("[TB] FAIL b2b_total got %0d expected 48", pushes);
    end
  endtask

  task automatic test_broken_header();
    logic expPush;
    clearStim();
    addWord(16'hFFFF, 1'b1);
    addWord(16'h1234, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hAAAA, 1'b1);
    for (int k = 0; k < 16; k++) addWord(16'(k), 1'b1);
    repeat (2) addWord(16'h0000, 1'b1);
    applyStimulus();
    for (int i = 0; i < obsPush.size(); i++) begin
      expPush = (i >= 5 && i <= 20);
      testsRun++;
      if (obsPush[i] !== expPush) begin
        failCount++; $display("[TB] FAIL broken_push[%0d] got %b expected %b", i, obsPush[i], expPush);
      end
      if (expPush) begin
        testsRun++;
        if (obsData[i] !== 16'(i - 5)) begin
          failCount++; $display("[TB] FAIL broken_data[%0d] got %h expected %h", i, obsData[i], 16'(i - 5));
        end
      end
    end
  endtask

  task automatic test_payload_as_data();
    logic [15:0] payload[16];
    logic expPush;
    payload[0] = 16'h0001;
    payload[1] = 16'hFFFF;
    payload[2] = 16'hFFFF;
    payload[3] = 16'hAAAA;
    for (int k = 4; k < 16; k++) payload[k] = 16'(k + 1);
    clearStim();
    addWord(16'hFFFF, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hAAAA, 1'b1);
    for (int k = 0; k < 16; k++) addWord(payload[k], 1'b1);
    repeat (2) addWord(16'h0000, 1'b1);
    applyStimulus();
    for (int i = 0; i < obsPush.size(); i++) begin
      expPush = (i >= 4 && i <= 19);
      testsRun++;
      if (obsPush[i] !== expPush) begin
        failCount++; $display("[TB] FAIL data_push[%0d] got %b expected %b", i, obsPush[i], expPush);
      end
      if (expPush) begin
        testsRun++;
        if (obsData[i] !== payload[i - 4]) begin
          failCount++; $display("[TB] FAIL data_value[%0d] got %h expected %h", i, obsData[i], payload[i - 4]);
        end
      end
    end
  endtask

  task automatic test_go_control();
    logic expPush;
    int pushes;
    // GO low throughout: a complete header must not start a burst.
    clearStim();
    addWord(16'hFFFF, 1'b0);
    addWord(16'hFFFF, 1'b0);
    addWord(16'hAAAA, 1'b0);
    for (int k = 0; k < 16; k++) addWord(16'h0050 + 16'(k), 1'b0);
    applyStimulus();
    pushes = 0;
    foreach (obsPush[i]) if (obsPush[i] !== 1'b0) pushes++;
    testsRun++;
    if (pushes != 0) begin
      failCount++; $display("[TB] FAIL go_low_pushes got %0d expected 0", pushes);
    end
    // GO drops mid-burst; the burst finishes and the block lands in IDLE, so a header
    // arriving with GO just re-raised loses its first sync word and is not accepted.
    clearStim();
    addWord(16'h0000, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hAAAA, 1'b1);
    for (int k = 0; k < 16; k++) addWord(16'h0100 + 16'(k), (k < 3));
    addWord(16'hFFFF, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hAAAA, 1'b1);
    for (int k = 0; k < 4; k++) addWord(16'h0011 + 16'(k), 1'b1);
    repeat (3) addWord(16'h0000, 1'b1);
    applyStimulus();
    for (int i = 0; i < obsPush.size(); i++) begin
      expPush = (i >= 4 && i <= 19);
      testsRun++;
      if (obsPush[i] !== expPush) begin
        failCount++; $display("[TB] FAIL go_drop_push[%0d] got %b expected %b", i, obsPush[i], expPush);
      end
      if (expPush) begin
        testsRun++;
        if (obsData[i] !== 16'h0100 + 16'(i - 4)) begin
          failCount++; $display("[TB] FAIL go_drop_data[%0d] got %h expected %h", i, obsData[i], 16'h0100 + 16'(i - 4));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic expPush;
    int pushes;
    clearStim();
    addWord(16'hFFFF, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hAAAA, 1'b1);
    for (int k = 0; k < 5; k++) addWord(16'h0200 + 16'(k), 1'b1);
    applyStimulus();
    pushes = 0;
    foreach (obsPush[i]) if (obsPush[i] === 1'b1) pushes++;
    testsRun++;
    if (pushes != 5) begin
      failCount++; $display("[TB] FAIL rst_pre_pushes got %0d expected 5", pushes);
    end
    #2;
    RST_N = 1'b0;
    #1;
    testsRun++;
    if (PUSH !== 1'b0) begin
      failCount++; $display("[TB] FAIL rst_mid_push got %b expected 0", PUSH);
    end
    testsRun++;
    if (PIXEL_DATA !== 16'h0000) begin
      failCount++; $display("[TB] FAIL rst_mid_pixel got %h expected 0000", PIXEL_DATA);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    clearStim();
    for (int k = 5; k < 16; k++) addWord(16'h0200 + 16'(k), 1'b1);
    addWord(16'h0000, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hFFFF, 1'b1);
    addWord(16'hAAAA, 1'b1);
    for (int k = 0; k < 16; k++) addWord(16'h0300 + 16'(k), 1'b1);
    addWord(16'h0000, 1'b1);
    applyStimulus();
    for (int i = 0; i < obsPush.size(); i++) begin
      expPush = (i >= 15 && i <= 30);
      testsRun++;
      if (obsPush[i] !== expPush) begin
        failCount++; $display("[TB] FAIL rst_post_push[%0d] got %b expected %b", i, obsPush[i], expPush);
      end
      if (expPush) begin
        testsRun++;
        if (obsData[i] !== 16'h0300 + 16'(i - 15)) begin
          failCount++; $display("[TB] FAIL rst_post_data[%0d] got %h expected %h", i, obsData[i], 16'h0300 + 16'(i - 15));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_broken_header();
    test_payload_as_data();
    test_go_control();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
